// File: rtl/irq_pending_latch.sv
// Request-capture stage: latches request events as pending bits, feeds the masked
// vector to an external priority encoder and serves one index at a time over valid/ack.
module irq_pending_latch #(
  parameter bit EDGE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irq_in,
  input  logic [7:0] mask,
  output logic [7:0] pend_out,
  input  logic [2:0] enc_y,
  output logic       irq_valid,
  output logic [2:0] irq_idx,
  input  logic       irq_ack,
  output logic [7:0] overrun
);

  localparam int unsigned NCH = 8;
  localparam int unsigned IW  = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_GAP     = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [NCH-1:0]   pending_q, pending_d;
  logic [NCH-1:0]   prev_q;
  logic [NCH-1:0]   overrun_q, overrun_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [NCH-1:0]   event_c;
  logic [NCH-1:0]   clear_c;

  // Event detection and pending/overrun bookkeeping; a same-cycle event beats the ack clear.
  always_comb begin
    event_c   = EDGE ? (irq_in & ~prev_q) : irq_in;
    clear_c   = '0;
    if (state_q == ST_PRESENT && irq_ack) begin
      clear_c = NCH'(1) << idx_q;
    end
    pending_d = (pending_q & ~clear_c) | event_c;
    overrun_d = (overrun_q & ~(clear_c & ~event_c)) | (event_c & pending_q & ~clear_c);
  end

  // Presentation FSM: IDLE -> PRESENT until ack -> one GAP cycle for the encoder to settle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    unique case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        if (pend_out != '0) begin
          idx_d   = enc_y;
          valid_d = 1'b1;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        valid_d = 1'b1;
        if (irq_ack) begin
          valid_d = 1'b0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      prev_q    <= '0;
      overrun_q <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      prev_q    <= irq_in;
      overrun_q <= overrun_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
    end
  end

  assign pend_out  = pending_q & mask;
  assign irq_valid = valid_q;
  assign irq_idx   = idx_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Scoreboard bench: an edge-mode and a level-mode instance share request stimulus and
// are checked against a per-channel reference model through expectation queues.
module tb_irq_pending_latch;

  typedef struct {
    logic [7:0] pend;
    logic [7:0] ovr;
    logic       valid;
  } cyc_exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq_in;
  logic [7:0] mask;
  logic [1:0] ack;

  logic [7:0] pend_e, pend_l, ovr_e, ovr_l;
  logic [2:0] enc_e, enc_l, idx_e, idx_l;
  logic       valid_e, valid_l;

  int checks   = 0;
  int failures = 0;

  // Reference model state, index 0 = edge instance, 1 = level instance.
  logic [7:0] m_pend [2];
  logic [7:0] m_prev [2];
  logic [7:0] m_ovr  [2];
  logic [2:0] m_idx  [2];
  logic       m_present [2];
  logic       m_gap  [2];

  cyc_exp_t   cyc_q0 [$];
  cyc_exp_t   cyc_q1 [$];
  logic [2:0] idx_q0 [$];
  logic [2:0] idx_q1 [$];

  logic       mon_prev_valid [2];
  logic [2:0] mon_cur_idx [2];

  always #5 clk = ~clk;

  function automatic logic [2:0] hi_idx(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction

  // Behavioural stand-in for the downstream priority encoder.
  assign enc_e = hi_idx(pend_e);
  assign enc_l = hi_idx(pend_l);

  irq_pending_latch #(.EDGE(1'b1)) u_edge (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .mask(mask), .pend_out(pend_e),
    .enc_y(enc_e), .irq_valid(valid_e), .irq_idx(idx_e), .irq_ack(ack[0]), .overrun(ovr_e)
  );

  irq_pending_latch #(.EDGE(1'b0)) u_lvl (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .mask(mask), .pend_out(pend_l),
    .enc_y(enc_l), .irq_valid(valid_l), .irq_idx(idx_l), .irq_ack(ack[1]), .overrun(ovr_l)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_pend[m] = '0; m_prev[m] = '0; m_ovr[m] = '0; m_idx[m] = '0;
      m_present[m] = 1'b0; m_gap[m] = 1'b0;
    end
  endtask

  // Advance one model channel across a clock edge with the inputs presented at that edge.
  task automatic step_model(input int m, input logic [7:0] in, input logic [7:0] msk,
                            input logic a);
    logic [7:0] ev, clr, vis;
    cyc_exp_t   ce;
    vis = m_pend[m] & msk;
    ev  = (m == 0) ? (in & ~m_prev[m]) : in;
    clr = (m_present[m] && a) ? (8'(1) << m_idx[m]) : 8'h00;
    if (m_gap[m]) begin
      m_gap[m] = 1'b0;
    end else if (m_present[m]) begin
      if (a) begin
        m_present[m] = 1'b0;
        m_gap[m]     = 1'b1;
      end
    end else if (vis != 8'h00) begin
      m_idx[m]     = hi_idx(vis);
      m_present[m] = 1'b1;
      if (m == 0) idx_q0.push_back(m_idx[m]);
      else        idx_q1.push_back(m_idx[m]);
    end
    for (int i = 0; i < 8; i++) begin
      if (ev[i]) begin
        if (m_pend[m][i] && !clr[i]) m_ovr[m][i] = 1'b1;
        m_pend[m][i] = 1'b1;
      end else if (clr[i]) begin
        m_pend[m][i] = 1'b0;
        m_ovr[m][i]  = 1'b0;
      end
    end
    m_prev[m] = in;
    ce.pend  = m_pend[m] & msk;
    ce.ovr   = m_ovr[m];
    ce.valid = m_present[m];
    if (m == 0) cyc_q0.push_back(ce);
    else        cyc_q1.push_back(ce);
  endtask

  task automatic apply(input logic [7:0] in, input logic [7:0] msk, input logic a0,
                       input logic a1);
    irq_in = in;
    mask   = msk;
    ack    = {a1, a0};
    step_model(0, in, msk, a0);
    step_model(1, in, msk, a1);
  endtask

  task automatic drive(input logic [7:0] in, input logic [7:0] msk, input logic a0,
                       input logic a1);
    @(negedge clk);
    apply(in, msk, a0, a1);
  endtask

  // Hold a request pattern for n cycles, acknowledging immediately whenever presented.
  task automatic run_auto(input int n, input logic [7:0] in, input logic [7:0] msk);
    for (int c = 0; c < n; c++) drive(in, msk, m_present[0], m_present[1]);
  endtask

  task automatic mon_one(input int m, input logic [7:0] pend, input logic [7:0] ovr,
                         input logic valid, input logic [2:0] idx);
    cyc_exp_t ce;
    logic     have;
    have = (m == 0) ? (cyc_q0.size() > 0) : (cyc_q1.size() > 0);
    if (have) begin
      ce = (m == 0) ? cyc_q0.pop_front() : cyc_q1.pop_front();
      check($sformatf("pend_out[%0d]", m), pend, ce.pend);
      check($sformatf("overrun[%0d]", m), ovr, ce.ovr);
      check($sformatf("irq_valid[%0d]", m), 8'(valid), 8'(ce.valid));
    end
    if (valid && !mon_prev_valid[m]) begin
      if ((m == 0 && idx_q0.size() == 0) || (m == 1 && idx_q1.size() == 0)) begin
        check($sformatf("unexpected_valid[%0d]", m), 8'(valid), 8'h00);
      end else begin
        mon_cur_idx[m] = (m == 0) ? idx_q0.pop_front() : idx_q1.pop_front();
      end
    end
    if (valid) check($sformatf("irq_idx[%0d]", m), 8'(idx), 8'(mon_cur_idx[m]));
    mon_prev_valid[m] = valid;
  endtask

  initial begin
    mon_prev_valid[0] = 1'b0; mon_prev_valid[1] = 1'b0;
    mon_cur_idx[0] = '0;      mon_cur_idx[1] = '0;
  end

  always @(posedge clk) begin
    #1;
    mon_one(0, pend_e, ovr_e, valid_e, idx_e);
    mon_one(1, pend_l, ovr_l, valid_l, idx_l);
  end

  initial begin
    logic [7:0] rin, rmask;
    int         guard;
    rst_n  = 1'b0;
    irq_in = 8'h00;
    mask   = 8'hFF;
    ack    = 2'b00;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_pend_out", pend_e, 8'h00);
    check("reset_valid", 8'(valid_e), 8'h00);
    check("reset_overrun", ovr_e, 8'h00);
    check("reset_idx", 8'(idx_e), 8'h00);

    // Single event present from the first clock after reset.
    @(negedge clk);
    rst_n = 1'b1;
    apply(8'h04, 8'hFF, 1'b0, 1'b0);
    run_auto(9, 8'h04, 8'hFF);
    run_auto(6, 8'h00, 8'hFF);

    // Priority ordering 7, 5, 0.
    drive(8'hA1, 8'hFF, 1'b0, 1'b0);
    run_auto(12, 8'h00, 8'hFF);

    // Masked bit is retained and served once unmasked.
    drive(8'h82, 8'h7F, 1'b0, 1'b0);
    run_auto(8, 8'h00, 8'h7F);
    run_auto(8, 8'h00, 8'hFF);

    // Overrun, then an edge landing on its own ack cycle.
    drive(8'h08, 8'hFF, 1'b0, 1'b0);
    drive(8'h00, 8'hFF, 1'b0, 1'b0);
    drive(8'h08, 8'hFF, 1'b0, 1'b0);
    drive(8'h00, 8'hFF, 1'b0, 1'b0);
    drive(8'h00, 8'hFF, 1'b0, 1'b0);
    drive(8'h08, 8'hFF, m_present[0], m_present[1]);
    run_auto(10, 8'h00, 8'hFF);

    // Held level request is re-presented, then released.
    run_auto(10, 8'h80, 8'hFF);
    run_auto(8, 8'h00, 8'hFF);

    // Randomized traffic with sparse requests, occasional mask changes and random acks.
    rmask = 8'hFF;
    for (int c = 0; c < 1500; c++) begin
      rin = 8'($urandom) & 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 31) == 0) rmask = 8'($urandom) | 8'($urandom);
      drive(rin, rmask, 1'($urandom), 1'($urandom));
    end
    run_auto(40, 8'h00, 8'hFF);

    // Asynchronous reset mid-handshake.
    drive(8'hC0, 8'hFF, 1'b0, 1'b0);
    guard = 0;
    while (!m_present[0] && guard < 10) begin
      drive(8'h00, 8'hFF, 1'b0, 1'b0);
      guard++;
    end
    @(posedge clk);
    #2;
    check("pre_reset_valid", 8'(valid_e), 8'h01);
    check("pre_reset_pend", pend_e, 8'hC0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_reset_valid", 8'(valid_e), 8'h00);
    check("async_reset_pend", pend_e, 8'h00);
    check("async_reset_idx", 8'(idx_e), 8'h00);
    check("async_reset_ovr", ovr_e, 8'h00);
    check("async_reset_valid_lvl", 8'(valid_l), 8'h00);
    check("async_reset_pend_lvl", pend_l, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    apply(8'hFF, 8'hFF, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    check("edge_after_reset", pend_e, 8'hFF);
    run_auto(40, 8'h00, 8'hFF);

    repeat (3) @(negedge clk);
    check("leftover_cycle_exp", 8'(cyc_q0.size() + cyc_q1.size()), 8'h00);
    check("leftover_idx_exp", 8'(idx_q0.size() + idx_q1.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
